// File: rtl/alu_seq_n.sv
// Multi-cycle ALU: single-cycle logic/add-type ops and a WIDTH-cycle shift-add
// unsigned multiplier returning a full 2*WIDTH-bit product, under a start/done handshake.
module alu_seq_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_out,
  output logic             v,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpXor = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpSlt = 3'b110;
  localparam logic [2:0] OpNor = 3'b111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMulRun = 2'b01
  } state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [WIDTH-1:0]       result_hi_q, result_hi_d;
  logic                   c_out_q, c_out_d;
  logic                   v_q, v_d;
  logic                   zero_q, zero_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Single-cycle datapath
  logic                   subtract;
  logic [WIDTH-1:0]       b_eff;
  logic [WIDTH:0]         sum_full;
  logic                   carry_into_msb;
  logic                   add_v;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c;
  logic                   alu_v;
  logic [2*WIDTH-1:0]     prod_next;

  always_comb begin
    subtract       = (alu_op == OpSub) || (alu_op == OpSlt);
    b_eff          = subtract ? ~b : b;
    sum_full       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, subtract};
    // Carry into the MSB recovered from the MSB sum bit and its two inputs.
    carry_into_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
    add_v          = carry_into_msb ^ sum_full[WIDTH];

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (alu_op)
      OpAdd, OpSub: begin
        alu_res = sum_full[WIDTH-1:0];
        alu_c   = sum_full[WIDTH];
        alu_v   = add_v;
      end
      OpXor:   alu_res = a ^ b;
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpNor:   alu_res = ~(a | b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ add_v};
      OpMul:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    c_out_d     = c_out_q;
    v_d         = v_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (alu_op == OpMul) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = StMulRun;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            c_out_d     = alu_c;
            v_d         = alu_v;
            zero_d      = (alu_res == '0);
            done_d      = 1'b1;
          end
        end
      end
      StMulRun: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          {result_hi_d, result_d} = prod_next;
          c_out_d = 1'b0;
          v_d     = 1'b0;
          zero_d  = (prod_next == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      c_out_q     <= 1'b0;
      v_q         <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      c_out_q     <= c_out_d;
      v_q         <= v_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign c_out     = c_out_q;
  assign v         = v_q;
  assign zero      = zero_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n: directed corner cases plus random ops
// against an arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  alu_op;
  logic [31:0] a, b;
  logic [31:0] result, result_hi;
  logic        c_out, v, zero, busy, done;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [7:0]  r8, rh8;
  logic        c8, v8, z8, busy8, done8;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_r;

  always #5 clk = ~clk;

  alu_seq_n #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .c_out(c_out), .v(v), .zero(zero),
    .busy(busy), .done(done)
  );

  alu_seq_n #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .alu_op(op8), .a(a8), .b(b8),
    .result(r8), .result_hi(rh8), .c_out(c8), .v(v8), .zero(z8),
    .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model straight from the operation definitions.
  task automatic model(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                       output logic [31:0] r, output logic [31:0] rh,
                       output logic c, output logic ov);
    logic [32:0] s;
    logic [63:0] p;
    r = '0; rh = '0; c = 1'b0; ov = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, oa} + {1'b0, ob};
        r = s[31:0]; c = s[32];
        ov = (oa[31] == ob[31]) && (r[31] != oa[31]);
      end
      3'd1: begin
        r = oa - ob; c = (oa >= ob);
        ov = (oa[31] != ob[31]) && (r[31] != oa[31]);
      end
      3'd2: begin
        p = {32'b0, oa} * {32'b0, ob};
        r = p[31:0]; rh = p[63:32];
      end
      3'd3: r = oa ^ ob;
      3'd4: r = oa & ob;
      3'd5: r = oa | ob;
      3'd6: r = ($signed(oa) < $signed(ob)) ? 32'd1 : 32'd0;
      default: r = ~(oa | ob);
    endcase
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob);
    logic [31:0] er, erh;
    logic ec, ev, ez;
    model(op, oa, ob, er, erh, ec, ev);
    ez = (er == 0) && (erh == 0);
    start = 1'b1; alu_op = op; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    check("op_result", 64'(result), 64'(er));
    check("op_result_hi", 64'(result_hi), 64'(erh));
    check("op_flags_cvzdb", 64'({c_out, v, zero, done, busy}), 64'({ec, ev, ez, 1'b1, 1'b0}));
    exp_r = er;
  endtask

  task automatic do_mul(input logic [31:0] oa, input logic [31:0] ob);
    logic [31:0] er, erh;
    logic ec, ev, ez, gap;
    int k;
    model(3'd2, oa, ob, er, erh, ec, ev);
    ez = (er == 0) && (erh == 0);
    start = 1'b1; alu_op = 3'd2; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    check("mul_accept_busy_done", 64'({busy, done}), 64'(2'b10));
    k = 0; gap = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (!done && !busy) gap = 1'b1;
      if (k == 3) begin a = $urandom; b = $urandom; end
      if (k == 5) begin start = 1'b1; alu_op = 3'd0; end
      if (k == 6) start = 1'b0;
    end
    start = 1'b0;
    check("mul_latency", 64'(k), 64'd32);
    check("mul_busy_held", 64'(gap), 64'd0);
    check("mul_result", 64'(result), 64'(er));
    check("mul_result_hi", 64'(result_hi), 64'(erh));
    check("mul_flags_cvzdb", 64'({c_out, v, zero, done, busy}), 64'({2'b00, ez, 2'b10}));
    @(posedge clk); #1;
    check("mul_done_pulse", 64'({done, busy}), 64'd0);
    check("mul_hold", 64'({result_hi, result}), {erh, er});
    exp_r = er;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    logic gap, seen;
    logic [2:0] rop;

    reset = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out32", 64'({result, result_hi} != 0), 64'd0);
    check("reset_flags32", 64'({c_out, v, zero, busy, done}), 64'd0);
    check("reset_out8", 64'({r8, rh8, c8, v8, z8, busy8, done8}), 64'd0);
    reset = 1'b0;

    // Directed corner cases
    do_op(3'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_exact", 64'({result, c_out, v}), 64'({32'h8000_0000, 1'b0, 1'b1}));
    do_op(3'd1, 32'd5, 32'd7);
    check("sub_5_7_exact", 64'({result, c_out, v}), 64'({32'hFFFF_FFFE, 1'b0, 1'b0}));
    do_op(3'd1, 32'd7, 32'd7);
    check("sub_7_7_exact", 64'({result, zero, c_out}), 64'({32'h0, 1'b1, 1'b1}));
    do_op(3'd6, 32'hFFFF_FFFF, 32'h1);
    check("slt_m1_1", 64'(result), 64'd1);
    do_op(3'd6, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_min_max", 64'(result), 64'd1);
    do_op(3'd6, 32'h1, 32'hFFFF_FFFF);
    check("slt_1_m1", 64'(result), 64'd0);
    do_mul(32'hFFFF_FFFF, 32'h2);
    check("mul_ff_2_exact", {result_hi, result}, 64'h1_FFFF_FFFE);
    do_mul(32'h0, 32'h1234_5678);
    check("mul_zero_flag", 64'(zero), 64'd1);

    // Random back-to-back ops
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop == 3'd2) do_mul(pick(), pick());
      else do_op(rop, pick(), pick());
    end
    @(posedge clk); #1;
    check("idle_done_low", 64'(done), 64'd0);
    check("idle_hold", 64'(result), 64'(exp_r));

    // Reset in the middle of a multiply
    do_op(3'd0, 32'd1, 32'd1);
    start = 1'b1; alu_op = 3'd2; a = 32'hFFFF_FFFF; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_mul_out", 64'({result, result_hi} != 0), 64'd0);
    check("rst_mid_mul_flags", 64'({c_out, v, zero, busy, done}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);
    do_op(3'd0, 32'd3, 32'd4);
    check("add_after_rst", 64'(result), 64'd7);

    // Start coincident with reset: reset wins
    start = 1'b1; alu_op = 3'd0; a = 32'd10; b = 32'd20; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("start_rst_coincide", 64'({result, done}), 64'd0);

    // WIDTH=8 multiply
    start8 = 1'b1; op8 = 3'd2; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    k = 0; gap = 1'b0;
    while (!done8 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (!done8 && !busy8) gap = 1'b1;
    end
    check("mul8_latency", 64'(k), 64'd8);
    check("mul8_busy_held", 64'(gap), 64'd0);
    check("mul8_product", 64'({rh8, r8}), 64'h0000_FE01);
    check("mul8_flags", 64'({c8, v8, z8, busy8}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
